// File: rtl/serial_nibble_loader_if.sv
// serial_nibble_loader_if
//   Bundles the serial input side and the word/handshake/status side of
//   serial_nibble_loader. clk and clr_n stay plain ports on the module.
//   Signals:
//     sin      serial data, meaningful only when bit_en=1
//     bit_en   one-cycle bit strobe, one per bit time
//     rdy      downstream accepts q this cycle
//     flag_clr synchronous clear of the sticky ovr/perr flags
//     q        assembled word, stable while q_vld=1
//     q_vld    q holds an unconsumed word
//     busy     receiver is inside a frame
//     ferr     one-cycle pulse: stop bit sampled as 0
//     ovr      sticky: good frame dropped, holding slot was full
//     perr     sticky parity error (tied 0 without PARITY_CHK_EN)
//   Modports: master = feeder/consumer side, slave = the loader itself.
interface serial_nibble_loader_if #(
  parameter int WIDTH = 4
);
  logic             sin;
  logic             bit_en;
  logic             rdy;
  logic             flag_clr;
  logic [WIDTH-1:0] q;
  logic             q_vld;
  logic             busy;
  logic             ferr;
  logic             ovr;
  logic             perr;

  modport master (
    output sin, bit_en, rdy, flag_clr,
    input  q, q_vld, busy, ferr, ovr, perr
  );

  modport slave (
    input  sin, bit_en, rdy, flag_clr,
    output q, q_vld, busy, ferr, ovr, perr
  );
endinterface

// File: rtl/serial_nibble_loader.sv
// serial_nibble_loader
//   Receives a framed serial stream (start bit 0, WIDTH data bits, optional
//   even-parity bit, stop bit 1), assembles the data word and offers it on
//   bus.q with a valid/ready handshake. The consumer takes q when
//   q_vld && rdy. Flags framing (ferr pulse), overrun (sticky ovr) and parity
//   (sticky perr) errors.
//
//   Build option: define PARITY_CHK_EN to add the parity bit to the frame and
//   enable parity checking; without it the frame is start+WIDTH+stop and perr
//   is tied to 0.
//
//   Parameters:
//     WIDTH      data bits per frame, 2..8
//     MSB_FIRST  0: first data bit lands in q[0]; 1: lands in q[WIDTH-1]
//   Ports:
//     clk    rising-edge system clock
//     clr_n  asynchronous active-low reset
//     bus    serial_nibble_loader_if.slave (see interface header)
module serial_nibble_loader #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   clr_n,
  serial_nibble_loader_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2, PAR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, STOP = 2'd2} state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr, sr_shift;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic             q_vld_r;
  logic             ferr_r;
  logic             ovr_r;

  // Strobes decoded by the FSM for the datapath.
  logic             shift_en;   // shift sin into the word
  logic             last_bit;   // current data bit is the WIDTH-th
  logic             stop_ok;    // good stop bit sampled
  logic             stop_bad;   // stop bit sampled as 0
  logic             load;       // good word goes into the holding slot
  logic             drop;       // good word lost, slot full and not freed

  assign last_bit = (cnt == CW'(WIDTH - 1));

  // Shift direction decides which end of q the first data bit ends up in.
  always_comb begin
    sr_shift = sr;
    if (MSB_FIRST) sr_shift = {sr[WIDTH-2:0], bus.sin};
    else           sr_shift = {bus.sin, sr[WIDTH-1:1]};
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef PARITY_CHK_EN
  logic par_chk;  // parity bit is being sampled this cycle
`endif

  always_comb begin
    state_nxt = state;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
`ifdef PARITY_CHK_EN
    par_chk   = 1'b0;
`endif
    if (bus.bit_en) begin
      case (state)
        IDLE: if (!bus.sin) state_nxt = DATA;
        DATA: begin
          shift_en = 1'b1;
`ifdef PARITY_CHK_EN
          if (last_bit) state_nxt = PAR;
`else
          if (last_bit) state_nxt = STOP;
`endif
        end
`ifdef PARITY_CHK_EN
        PAR: begin
          par_chk   = 1'b1;
          state_nxt = STOP;
        end
`endif
        STOP: begin
          // Return straight to IDLE so a start bit on the very next strobe
          // is picked up.
          if (bus.sin) stop_ok  = 1'b1;
          else         stop_bad = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Slot is usable if empty or being emptied by the consumer on this edge.
  assign load = stop_ok && (!q_vld_r || bus.rdy);
  assign drop = stop_ok && q_vld_r && !bus.rdy;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift_en) begin
      sr  <= sr_shift;
      // Counter only ever wraps here, on the last data bit.
      cnt <= last_bit ? '0 : cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_r     <= '0;
      q_vld_r <= 1'b0;
    end else if (load) begin
      q_r     <= sr;
      q_vld_r <= 1'b1;
    end else if (q_vld_r && bus.rdy) begin
      q_vld_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) ferr_r <= 1'b0;
    else        ferr_r <= stop_bad;
  end

  // Set takes priority over flag_clr so a coincident event is never lost.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)            ovr_r <= 1'b0;
    else if (drop)         ovr_r <= 1'b1;
    else if (bus.flag_clr) ovr_r <= 1'b0;
  end

`ifdef PARITY_CHK_EN
  logic par_acc;  // running XOR of the data bits of the current frame
  logic perr_r;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                                  par_acc <= 1'b0;
    else if (state == IDLE && bus.bit_en)        par_acc <= 1'b0;
    else if (shift_en)                           par_acc <= par_acc ^ bus.sin;
  end

  // Even parity: data bits plus parity bit must XOR to 0.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)                          perr_r <= 1'b0;
    else if (par_chk && (par_acc ^ bus.sin)) perr_r <= 1'b1;
    else if (bus.flag_clr)               perr_r <= 1'b0;
  end

  assign bus.perr = perr_r;
`else
  assign bus.perr = 1'b0;
`endif

  assign bus.q     = q_r;
  assign bus.q_vld = q_vld_r;
  assign bus.busy  = (state != IDLE);
  assign bus.ferr  = ferr_r;
  assign bus.ovr   = ovr_r;

endmodule
